// File: rtl/potential_mem_arbiter_pkg.sv
// Shared constants and types for the membrane-potential store and its arbiter.
package potential_mem_pkg;

    localparam int SUM_WIDTH     = 13;
    localparam int ADDR_WIDTH    = 9;
    localparam int OUTPUT_DIM    = 21;
    localparam int NUM_NEURONS   = OUTPUT_DIM * OUTPUT_DIM;
    localparam int NUM_REQ       = 5;
    localparam int NUM_TIMESTEPS = 2;

    typedef logic [SUM_WIDTH-1:0]  potential_t;
    typedef logic [ADDR_WIDTH-1:0] neuron_addr_t;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } ts_state_e;

endpackage

// File: rtl/potential_mem_arbiter_if.sv
// SPE-side request/response bundle plus timestep status for the potential store.
interface potential_mem_arbiter_if #(
    parameter int NUM_REQ       = 5,
    parameter int SUM_WIDTH     = 13,
    parameter int ADDR_WIDTH    = 9,
    parameter int NUM_TIMESTEPS = 2
) ();
    import potential_mem_pkg::*;

    localparam int TS_WIDTH = $clog2(NUM_TIMESTEPS + 1);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*SUM_WIDTH-1:0]  req_wdata;
    logic [NUM_REQ-1:0]            req_spike;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [SUM_WIDTH-1:0]          rsp_data;
    logic [TS_WIDTH-1:0]           timestep;
    logic                          ts_done;
    logic [ADDR_WIDTH:0]           spike_count;
    logic                          all_done;
    logic                          err_addr;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_spike,
        input  req_ready, rsp_valid, rsp_data, timestep, ts_done,
               spike_count, all_done, err_addr
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_spike,
        output req_ready, rsp_valid, rsp_data, timestep, ts_done,
               spike_count, all_done, err_addr
    );

endinterface

// File: rtl/potential_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer,
// pointer moves just past the winner when the grant is accepted.
module rr_arbiter #(
    parameter int NUM_REQ = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant
);
    import potential_mem_pkg::*;

    localparam int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_WIDTH-1:0] ptr_q;
    logic [PTR_WIDTH-1:0] ptr_next;
    logic                 found;

    // Two passes: requesters at/after the pointer first, then the wrap-around
    always_comb begin
        grant    = '0;
        ptr_next = ptr_q;
        found    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr_q))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
                ptr_next = (i == NUM_REQ - 1) ? '0 : PTR_WIDTH'(i + 1);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i < int'(ptr_q))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
                ptr_next = (i == NUM_REQ - 1) ? '0 : PTR_WIDTH'(i + 1);
            end
        end
    end

    // Pointer only advances on an accepted grant; idle cycles hold it
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= ptr_next;
        end
    end

endmodule

// File: rtl/potential_mem_arbiter.sv
// Membrane-potential store shared by the SPE array, with round-robin access
// and timestep sequencing.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   RUN   | accepting reads/writes, counting in-range neuron writes
//   DONE  | last timestep finished; no grants or responses until reset
module potential_mem_arbiter #(
    parameter int NUM_REQ       = 5,
    parameter int SUM_WIDTH     = 13,
    parameter int OUTPUT_DIM    = 21,
    parameter int ADDR_WIDTH    = 9,
    parameter int NUM_TIMESTEPS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    potential_mem_arbiter_if.slave bus
);
    import potential_mem_pkg::*;

    localparam int N_NEURONS = OUTPUT_DIM * OUTPUT_DIM;
    localparam int TS_WIDTH  = $clog2(NUM_TIMESTEPS + 1);
    localparam int CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [TS_WIDTH-1:0] TS_LAST = TS_WIDTH'(NUM_TIMESTEPS - 1);

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic                  gnt_any;
    logic                  sel_write;
    logic                  sel_spike;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [SUM_WIDTH-1:0]  sel_wdata;
    logic                  in_range;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  wr_last;
    logic [SUM_WIDTH-1:0]  rsp_data_q;
    logic [SUM_WIDTH-1:0]  mem [N_NEURONS];
    logic [CNT_WIDTH-1:0]  wr_count;
    logic [CNT_WIDTH-1:0]  spike_cnt;
    logic                  err_q;
    logic [TS_WIDTH-1:0]   ts_q;
    logic [TS_WIDTH-1:0]   ts_d;
    logic                  ts_done_q;
    logic                  ts_done_d;
    ts_state_e             state_q;
    ts_state_e             state_d;

    // A requester waiting on its read response sits out one round so the
    // shared rsp_data is never overwritten before it is consumed.
    assign eligible = bus.req_valid & ~rsp_valid_q
                    & {NUM_REQ{(state_q == RUN) && !reset}};
    assign gnt_any  = |grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .clk    (clk),
        .reset  (reset),
        .req    (eligible),
        .accept (gnt_any),
        .grant  (grant)
    );

    // Steer the granted requester's fields onto the single memory port
    always_comb begin
        sel_write = 1'b0;
        sel_spike = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_write = bus.req_write[i];
                sel_spike = bus.req_spike[i];
                sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.req_wdata[i*SUM_WIDTH +: SUM_WIDTH];
            end
        end
    end

    assign in_range = (int'(sel_addr) < N_NEURONS);
    assign wr_fire  = gnt_any && sel_write && in_range;
    assign rd_fire  = gnt_any && !sel_write;
    assign wr_last  = wr_fire && (wr_count == CNT_WIDTH'(N_NEURONS - 1));

    // Potential store writes; left unreset so it maps onto a RAM
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

    // Read response one cycle after the grant; timestep 0 hides stale contents
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rd_fire ? grant : '0;
            if (rd_fire) begin
                rsp_data_q <= ((ts_q == '0) || !in_range) ? '0 : mem[sel_addr];
            end
        end
    end

    // Per-timestep write and spike counters, plus the sticky address error
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count  <= '0;
            spike_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            if (gnt_any && !in_range) begin
                err_q <= 1'b1;
            end
            if (wr_last) begin
                wr_count  <= '0;
                spike_cnt <= '0;
            end else if (wr_fire) begin
                wr_count  <= wr_count + CNT_WIDTH'(1);
                spike_cnt <= spike_cnt + CNT_WIDTH'(sel_spike);
            end
        end
    end

    // Timestep FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            ts_q      <= '0;
            ts_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_d;
            ts_done_q <= ts_done_d;
        end
    end

    // Timestep FSM next-state: the final write of the last timestep parks in DONE
    always_comb begin
        state_d   = state_q;
        ts_d      = ts_q;
        ts_done_d = 1'b0;
        case (state_q)
            RUN: begin
                if (wr_last) begin
                    ts_done_d = 1'b1;
                    if (ts_q == TS_LAST) begin
                        state_d = DONE;
                    end else begin
                        ts_d = ts_q + TS_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Reset squashes a response that is already on the wire this cycle
    assign bus.req_ready   = grant;
    assign bus.rsp_valid   = rsp_valid_q & {NUM_REQ{!reset}};
    assign bus.rsp_data    = rsp_data_q;
    assign bus.timestep    = ts_q;
    assign bus.ts_done     = ts_done_q;
    assign bus.spike_count = spike_cnt;
    assign bus.all_done    = (state_q == DONE);
    assign bus.err_addr    = err_q;

endmodule

// File: tb/tb_potential_mem_arbiter.sv
// Directed bench for potential_mem_arbiter with a read-response scoreboard
// and a small reference model of arbitration, storage and timestep counting.
module tb_potential_mem_arbiter;

    localparam int NR  = 5;
    localparam int AW  = 9;
    localparam int SW  = 13;
    localparam int NN  = 441;

    typedef struct {
        int          spe;
        logic [SW-1:0] data;
    } sb_t;

    logic clk;
    logic reset;

    potential_mem_arbiter_if bus ();

    potential_mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    sb_t sb[$];

    logic [NR-1:0] t_valid;
    logic [NR-1:0] t_write;
    logic [NR-1:0] t_spike;
    logic [AW-1:0] t_addr [NR];
    logic [SW-1:0] t_data [NR];

    logic [SW-1:0] model_mem [512];
    int            model_ptr;
    logic [NR-1:0] model_pend;
    int            model_wr;
    int            model_spk;
    int            model_ts;
    logic          model_done;
    logic          model_err;
    logic          model_tsd;
    int            tsd_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_ptr  = 0;
        model_pend = '0;
        model_wr   = 0;
        model_spk  = 0;
        model_ts   = 0;
        model_done = 1'b0;
        model_err  = 1'b0;
        model_tsd  = 1'b0;
        sb.delete();
    endtask

    function automatic logic [NR-1:0] model_pick();
        logic [NR-1:0] elig;
        elig = t_valid & ~model_pend & {NR{~model_done}};
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (model_ptr + k) % NR;
            if (elig[i]) return NR'(1) << i;
        end
        return '0;
    endfunction

    function automatic logic [SW-1:0] exp_read(input logic [AW-1:0] a);
        if (model_ts == 0 || int'(a) >= NN) return '0;
        return model_mem[a];
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [SW-1:0] d, input logic s);
        model_mem[a] = d;
        model_wr++;
        model_spk += int'(s);
        if (model_wr == NN) begin
            model_wr  = 0;
            model_spk = 0;
            model_tsd = 1'b1;
            if (model_ts == 1) model_done = 1'b1;
            else model_ts++;
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[i*AW +: AW]  = t_addr[i];
            bus.req_wdata[i*SW +: SW] = t_data[i];
        end
        bus.req_valid = t_valid;
        bus.req_write = t_write;
        bus.req_spike = t_spike;
    endtask

    task automatic step();
        sb_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.spe);
            check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        end else begin
            check("rsp_idle", 32'(bus.rsp_valid), 32'd0);
        end
    endtask

    task automatic drive_cycle();
        logic [NR-1:0] g;
        sb_t e;
        apply();
        #1;
        g = model_pick();
        check("grant", 32'(bus.req_ready), 32'(g));
        model_tsd  = 1'b0;
        model_pend = '0;
        for (int i = 0; i < NR; i++) begin
            if (g[i]) begin
                model_ptr = (i + 1) % NR;
                if (int'(t_addr[i]) >= NN) model_err = 1'b1;
                if (!t_write[i]) begin
                    e.spe  = i;
                    e.data = exp_read(t_addr[i]);
                    sb.push_back(e);
                    model_pend = g;
                end else if (int'(t_addr[i]) < NN) begin
                    model_write(t_addr[i], t_data[i], t_spike[i]);
                end
            end
        end
        step();
        if (bus.ts_done === 1'b1) tsd_seen++;
        check("ts_done", 32'(bus.ts_done), 32'(model_tsd));
        check("timestep", 32'(bus.timestep), 32'(model_ts));
        check("spike_count", 32'(bus.spike_count), 32'(model_spk));
        check("all_done", 32'(bus.all_done), 32'(model_done));
        check("err_addr", 32'(bus.err_addr), 32'(model_err));
    endtask

    task automatic set_one(input int spe, input logic w, input int addr, input int data, input logic s);
        t_valid      = '0;
        t_valid[spe] = 1'b1;
        t_write[spe] = w;
        t_addr[spe]  = AW'(addr);
        t_data[spe]  = SW'(data);
        t_spike[spe] = s;
    endtask

    task automatic read1(input int spe, input int addr);
        set_one(spe, 1'b0, addr, 0, 1'b0);
        drive_cycle();
    endtask

    task automatic write1(input int spe, input int addr, input int data, input logic s);
        set_one(spe, 1'b1, addr, data, s);
        drive_cycle();
    endtask

    task automatic idle();
        t_valid = '0;
        drive_cycle();
    endtask

    task automatic bulk_writes();
        for (int a = 0; a < NN; a++) begin
            write1(a % NR, a, (a == 7) ? 100 : (a * 3 + 1), (a % 3) == 0);
        end
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        t_valid = '0;
        t_write = '0;
        t_spike = '0;
        for (int i = 0; i < NR; i++) begin
            t_addr[i] = '0;
            t_data[i] = '0;
        end
        tsd_seen = 0;
        model_reset();

        // Reset: grants blocked even with every requester asking
        reset   = 1'b1;
        t_valid = '1;
        apply();
        step();
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        step();
        t_valid = '0;
        apply();
        reset = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_timestep", 32'(bus.timestep), 32'd0);
        check("rst_ts_done", 32'(bus.ts_done), 32'd0);
        check("rst_spike_count", 32'(bus.spike_count), 32'd0);
        check("rst_all_done", 32'(bus.all_done), 32'd0);
        check("rst_err_addr", 32'(bus.err_addr), 32'd0);

        // Timestep-0 read, write, then read of the same neuron
        read1(2, 7);
        write1(0, 7, 100, 1'b1);
        read1(1, 7);
        idle();

        // Everyone requesting: grants must rotate
        t_valid = '1;
        t_write = '0;
        for (int i = 0; i < NR; i++) t_addr[i] = AW'(10 + i);
        for (int c = 0; c < 10; c++) drive_cycle();
        idle();

        // Out-of-range write and read
        write1(3, 450, 5, 1'b0);
        read1(4, 450);
        idle();

        // First full timestep of writes
        tsd_seen = 0;
        bulk_writes();
        check("ts_done_pulses", 32'(tsd_seen), 32'd1);
        check("ts1_timestep", 32'(bus.timestep), 32'd1);

        // Timestep-1 reads: stored data visible, write-first, out-of-range still 0
        read1(2, 7);
        write1(0, 20, 777, 1'b1);
        read1(1, 20);
        write1(3, 450, 9, 1'b0);
        read1(4, 450);
        idle();

        // Reset the cycle after a read grant squashes the response
        set_one(2, 1'b0, 9, 0, 1'b0);
        apply();
        #1;
        check("sq_grant", 32'(bus.req_ready), 32'b00100);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        t_valid = '0;
        apply();
        #1;
        check("sq_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("sq_rsp_valid_hold", 32'(bus.rsp_valid), 32'd0);
        check("sq_timestep", 32'(bus.timestep), 32'd0);
        check("sq_err_addr", 32'(bus.err_addr), 32'd0);
        check("sq_spike_count", 32'(bus.spike_count), 32'd0);
        reset = 1'b0;
        model_reset();

        // Pointer back at 0: all requesting -> SPE0 wins
        t_valid = '1;
        t_write = '0;
        drive_cycle();
        idle();

        // Two full timesteps to completion
        tsd_seen = 0;
        bulk_writes();
        bulk_writes();
        check("done_ts_pulses", 32'(tsd_seen), 32'd2);
        check("done_all_done", 32'(bus.all_done), 32'd1);
        check("done_timestep", 32'(bus.timestep), 32'd1);

        // Requests after completion are ignored
        read1(0, 5);
        write1(1, 6, 3, 1'b1);
        idle();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/potential_mem_arbiter.md
Name: potential_mem_arbiter

Overview:
- Owns the membrane-potential store for all output neurons and arbitrates access to it among NUM_REQ Sum PEs.
- Each SPE issues one "read previous potential" request and one "write new potential + spike" request per output neuron per timestep.
- Sequences timesteps: counts completed neuron writes, advances the timestep, flags first-timestep behaviour and overall completion.
- Sits between the SPE array and the output-memory/readout path.

Parameters:
- NUM_REQ, 5, number of SPE requesters.
- SUM_WIDTH, 13, membrane potential width.
- OUTPUT_DIM, 21, output feature-map side; neuron count = OUTPUT_DIM*OUTPUT_DIM (441).
- ADDR_WIDTH, 9, neuron address width; must satisfy 2**ADDR_WIDTH >= OUTPUT_DIM**2.
- NUM_TIMESTEPS, 2, timesteps per inference.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-SPE request valid.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed neuron address, SPE i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*SUM_WIDTH  packed new potential.
- req_spike  in  NUM_REQ  spike bit accompanying a write.
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid&ready.
- rsp_valid  out  NUM_REQ  one-hot read-response strobe.
- rsp_data  out  SUM_WIDTH  read data, shared, qualified by rsp_valid.
- timestep  out  $clog2(NUM_TIMESTEPS+1)  current timestep, 0-based.
- ts_done  out  1  one-cycle pulse when a timestep completes.
- spike_count  out  ADDR_WIDTH+1  spikes written in the current timestep.
- all_done  out  1  held high after the last timestep completes.
- err_addr  out  1  sticky: an out-of-range address was accepted.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, timestep=0, ts_done=0, spike_count=0, all_done=0, err_addr=0. Round-robin pointer = 0, write counter = 0. Memory contents are not cleared; the timestep-0 read rule makes stale data invisible.
- Arbitration:
  - Combinational round-robin over eligible requesters, at most one grant per cycle.
  - Search starts at the pointer; after a grant to i, the pointer becomes (i+1) mod NUM_REQ. With no grant, the pointer holds.
  - Eligible = req_valid & ~read_pending & ~all_done.
  - read_pending[i] is set for the one cycle after a read grant to i.
- Handshake: a request is consumed on the clk edge where valid&ready. The requester may present its next request in the following cycle. Deasserting valid before a grant withdraws the request without penalty.
- Read:
  - Granted at edge T; rsp_valid[i]=1 for exactly the cycle after T.
  - rsp_data = stored potential, or 0 if timestep==0 or the address is out of range.
- Write:
  - Committed at the grant edge.
  - Stores wdata; spike_count += req_spike.
  - Write counter += 1 for in-range addresses.
  - Write-first: a read granted the cycle after a write to the same address returns the new value.
- Out-of-range address (>= OUTPUT_DIM**2): request is still granted and acknowledged; write is dropped and not counted; read returns 0; err_addr set until reset.
- Timestep FSM, states RUN and DONE:
  - RUN: when the write counter reaches OUTPUT_DIM**2 on a write edge, ts_done pulses the next cycle and the write counter and spike_count clear.
  - If timestep==NUM_TIMESTEPS-1, go to DONE, all_done=1, timestep unchanged. Otherwise timestep+1.
  - A read granted on the same edge as the completing write uses the pre-increment timestep.
  - DONE: no grants and no responses; only reset exits.
- Reset mid-operation wins over everything: a pending rsp_valid is squashed and counters and FSM return to reset values.

Decomposition:
- Package potential_mem_pkg: SUM_WIDTH, ADDR_WIDTH, OUTPUT_DIM defaults, NUM_NEURONS constant, typedef potential_t, typedef neuron_addr_t, typedef ts_state_e {RUN, DONE}.
- Sub-module rr_arbiter (NUM_REQ parameter; req vector in, one-hot grant out, pointer update on a grant-accepted input); reused elsewhere in the design.
- Storage is an inferred single-port array inside the top.

Test Plan:
- After reset, SPE2 reads addr 7 in timestep 0 -> rsp_valid=5'b00100 one cycle later, rsp_data=0.
- SPE0 writes addr 7 = 100 with spike=1, next cycle SPE1 reads addr 7 (timestep 0) -> rsp_data=0, spike_count=1. The same read in timestep 1 -> rsp_data=100.
- All 5 SPEs hold req_valid for 10 cycles -> grants rotate in order 0,1,2,3,4,0,...; no requester is granted twice in a row while others wait.
- Write all 441 addresses -> ts_done pulses once, timestep=1, spike_count=0. Repeat the 441 writes -> all_done=1; a further request gets req_ready=0.
- Write to addr 450 -> err_addr=1 and the write counter is unchanged. Read addr 450 -> rsp_data=0.
- Assert reset the cycle after a read grant -> rsp_valid stays 0, timestep=0, pointer=0.
